dbus_arbiter: RTL and testbench

- Shares the single data bus between N_REQ requesters: requester 0 is the IF-stage MMU page-table walker, requester 1 is the MEM-stage load/store unit.
- Latches one request at grant time and drives it to the bus unchanged until the bus returns data_ok.
- Routes the response back to the owner only.
- Provides flush handling so a squashed owner's in-flight transfer drains without corrupting the next transfer.

---
 rtl/dbus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
//   Shares the single data bus between N_REQ requesters. Requester 0 is the
//   IF-stage MMU page-table walker, requester 1 the MEM-stage load/store unit.
//   The winning request is latched at grant time and presented to the bus
//   unchanged until the bus answers with data_ok. The bus response is routed
//   back to the owner only. A squashed owner's transfer is drained (never
//   withdrawn from the bus) with its response suppressed.
//
// Build option:
//   DBUS_ARB_RR_EN  defined   -> round-robin arbitration, search starts at
//                                (last_owner + 1) mod N_REQ
//                   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous reset, active-low
//   req_i    in   per-requester request (valid, addr, size, strobe, data)
//   resp_o   out  per-requester response (addr_ok, data_ok, data)
//   dreq     out  request to the shared data bus (registered)
//   dresp    in   response from the shared data bus
//   flush_i  in   per-requester squash
//   grant_o  out  one-hot current owner, zero when idle
//   busy_o   out  a bus transfer is outstanding
// -----------------------------------------------------------------------------
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  dbus_req_t  [N_REQ-1:0] req_i,
  output dbus_resp_t [N_REQ-1:0] resp_o,
  output dbus_req_t              dreq,
  input  dbus_resp_t             dresp,
  input  logic       [N_REQ-1:0] flush_i,
  output logic       [N_REQ-1:0] grant_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  dbus_req_t        r_dreq;
  logic [N_REQ-1:0] r_grant;
  logic [ID_W-1:0]  r_owner;

  logic [N_REQ-1:0] w_qual;
  logic             w_any;
  logic [ID_W-1:0]  w_winner;
  logic             w_owner_flush;
  logic             w_load;

  // A flushed requester is excluded from arbitration in the same cycle.
  always_comb begin
    w_qual = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_qual[k] = req_i[k].valid & ~flush_i[k];
    end
  end

  assign w_any         = |w_qual;
  assign w_owner_flush = flush_i[r_owner];

`ifdef DBUS_ARB_RR_EN
  logic [ID_W-1:0] r_last;
  logic            w_found;

  // Search starts one past the previous owner and wraps around.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_found && w_qual[(int'(r_last) + i) % N_REQ]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_last) + i) % N_REQ);
      end
    end
  end

  // Reset to the highest index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= ID_W'(N_REQ - 1);
    end else if (w_load) begin
      r_last <= w_winner;
    end
  end
`else
  // Scanning downward leaves the lowest qualifying index as the winner.
  always_comb begin
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_qual[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end
`endif

  // Next-state and response routing. The owner's response is cut off in the
  // very cycle its flush arrives, including a coincident data_ok.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    resp_o       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next_state = S_BUSY;
          w_load       = 1'b1;
        end
      end
      S_BUSY: begin
        if (!w_owner_flush) begin
          resp_o[r_owner] = dresp;
        end
        if (dresp.data_ok) begin
          w_next_state = S_IDLE;
        end else if (w_owner_flush) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dresp.data_ok) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The latched request stays valid through DRAIN: an issued transfer is
  // never pulled back from the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dreq  <= '0;
      r_grant <= '0;
      r_owner <= '0;
    end else if (w_load) begin
      r_dreq  <= req_i[w_winner];
      r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
      r_owner <= w_winner;
    end else if (w_next_state == S_IDLE) begin
      r_dreq.valid <= 1'b0;
      r_grant      <= '0;
    end
  end

  assign dreq    = r_dreq;
  assign grant_o = r_grant;
  assign busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbus_arbiter
//   Randomized bench for dbus_arbiter. A transaction-level reference model
//   (current owner, squashed flag, held request) predicts grants, per-cycle
//   status and forwarded responses; expectations are queued when stimulus is
//   issued and a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam int N = 2;

`ifdef DBUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  dbus_req_t  [N-1:0]   req_i;
  dbus_resp_t [N-1:0]   resp_o;
  dbus_req_t            dreq;
  dbus_resp_t           dresp;
  logic       [N-1:0]   flush_i;
  logic       [N-1:0]   grant_o;
  logic                 busy_o;

  dbus_arbiter #(.N_REQ(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .resp_o  (resp_o),
    .dreq    (dreq),
    .dresp   (dresp),
    .flush_i (flush_i),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int        cyc;
    int        owner;
  } grant_rec_t;

  typedef struct {
    int          cyc;
    int          owner;
    logic [63:0] data;
  } resp_rec_t;

  typedef struct {
    logic              busy;
    logic [N-1:0]      grant;
    dbus_req_t         held;
    logic [N-1:0]      addrOk;
    logic [N-1:0]      dataOk;
    logic [N-1:0][63:0] data;
  } status_rec_t;

  grant_rec_t  grantQ[$];
  resp_rec_t   respQ[$];
  status_rec_t statusQ[$];

  int checks = 0;
  int passes = 0;
  int cycle  = 0;
  bit running = 1'b0;

  // Reference model: who owns the bus, whether it was squashed, what it holds.
  int        mOwner;
  bit        mSquashed;
  dbus_req_t mHeld;
  int        lastOwner;

  // Inputs as the DUT saw them at the most recent edge.
  dbus_req_t [N-1:0] pReq;
  logic      [N-1:0] pFlush;
  logic              pDataOk;

  // Requester behaviour and stimulus knobs (percentages).
  bit [N-1:0] active;
  bit [N-1:0] respSeen;
  bit [N-1:0] abandon;
  int pNewPct, flushPct, okPct, strayPct, chgPct;

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic void checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endfunction

  function automatic void noExpectation(string name);
    checks++;
    $display("[TB] FAIL %s: DUT produced an output with no expected entry (cycle %0d)", name, cycle);
  endfunction

  function automatic int pickWinner(logic [N-1:0] cand, int last);
    int start;
    start = RR ? (last + 1) % N : 0;
    for (int i = 0; i < N; i++) begin
      if (cand[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic randFields(int k);
    req_i[k].addr   = $urandom;
    req_i[k].size   = 3'($urandom_range(0, 3));
    req_i[k].strobe = 8'($urandom);
    req_i[k].data   = {$urandom, $urandom};
  endtask

  task automatic resetModel();
    mOwner    = -1;
    mSquashed = 1'b0;
    mHeld     = '0;
    lastOwner = N - 1;
    pReq      = '0;
    pFlush    = '0;
    pDataOk   = 1'b0;
    active    = '0;
    respSeen  = '0;
    abandon   = '0;
    req_i     = '0;
    flush_i   = '0;
    dresp     = '0;
  endtask

  // Apply what happened at the edge just passed to the transaction model.
  task automatic modelAdvance();
    logic [N-1:0] cand;
    int           w;
    grant_rec_t   g;
    if (mOwner < 0) begin
      for (int k = 0; k < N; k++) cand[k] = pReq[k].valid && !pFlush[k];
      w = pickWinner(cand, lastOwner);
      if (w >= 0) begin
        mOwner    = w;
        mSquashed = 1'b0;
        mHeld     = pReq[w];
        lastOwner = w;
        g.cyc     = cycle;
        g.owner   = w;
        grantQ.push_back(g);
      end
    end else if (pDataOk) begin
      mOwner = -1;
    end else if (pFlush[mOwner]) begin
      mSquashed = 1'b1;
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show this cycle.
  task automatic applyStimulus();
    status_rec_t s;
    resp_rec_t   r;
    for (int k = 0; k < N; k++) begin
      if (respSeen[k] || abandon[k]) begin
        active[k]   = 1'b0;
        respSeen[k] = 1'b0;
        abandon[k]  = 1'b0;
        if (pct(pNewPct)) begin active[k] = 1'b1; randFields(k); end
      end else if (!active[k]) begin
        if (pct(pNewPct)) begin active[k] = 1'b1; randFields(k); end
      end else if (pct(chgPct)) begin
        randFields(k);
      end
      req_i[k].valid = active[k];
      flush_i[k]     = pct(flushPct);
      if (flush_i[k] && active[k]) abandon[k] = 1'b1;
    end
    dresp.addr_ok = 1'($urandom_range(0, 1));
    dresp.data    = {$urandom, $urandom};
    dresp.data_ok = (mOwner >= 0) ? pct(okPct) : pct(strayPct);

    s.busy   = (mOwner >= 0);
    s.grant  = '0;
    s.held   = mHeld;
    s.addrOk = '0;
    s.dataOk = '0;
    s.data   = '0;
    if (mOwner >= 0) s.grant[mOwner] = 1'b1;
    if (mOwner >= 0 && !mSquashed && !flush_i[mOwner]) begin
      s.addrOk[mOwner] = dresp.addr_ok;
      s.dataOk[mOwner] = dresp.data_ok;
      s.data[mOwner]   = dresp.data;
      if (dresp.data_ok) begin
        r.cyc   = cycle;
        r.owner = mOwner;
        r.data  = dresp.data;
        respQ.push_back(r);
        respSeen[mOwner] = 1'b1;
      end
    end
    statusQ.push_back(s);
    pReq    = req_i;
    pFlush  = flush_i;
    pDataOk = dresp.data_ok;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle++;
    modelAdvance();
    applyStimulus();
  endtask

  task automatic setKnobs(int pn, int fl, int ok, int st, int ch);
    pNewPct = pn; flushPct = fl; okPct = ok; strayPct = st; chgPct = ch;
  endtask

  // Asynchronous reset during a transfer, then a lone request on requester 1.
  task automatic resetMidBusy();
    int guard;
    guard = 0;
    while (mOwner < 0 && guard < 200) begin
      stepCycle();
      guard++;
    end
    checkOutput("reset_setup_owner_found", 128'(mOwner >= 0), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_dreq_valid", 128'(dreq.valid), 128'(0));
    checkOutput("rst_grant_o", 128'(grant_o), 128'(0));
    checkOutput("rst_busy_o", 128'(busy_o), 128'(0));
    checkOutput("rst_resp_o", 128'(resp_o), 128'(0));
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cycle++;
    active[1] = 1'b1;
    randFields(1);
    setKnobs(0, 0, 30, 0, 0);
    applyStimulus();
  endtask

  // Monitor: status every cycle, grant contents on each new transfer,
  // forwarded responses whenever a data_ok appears.
  status_rec_t ms;
  grant_rec_t  mg;
  resp_rec_t   mr;
  logic        prevValid;

  always @(negedge clk) begin
    if (!rst || !running) begin
      prevValid = 1'b0;
    end else begin
      if (statusQ.size() == 0) begin
        noExpectation("status");
      end else begin
        ms = statusQ.pop_front();
        checkOutput("busy_o", 128'(busy_o), 128'(ms.busy));
        checkOutput("grant_o", 128'(grant_o), 128'(ms.grant));
        checkOutput("dreq.valid", 128'(dreq.valid), 128'(ms.busy));
        if (ms.busy) checkOutput("dreq_held", 128'(dreq), 128'(ms.held));
        for (int k = 0; k < N; k++) begin
          checkOutput($sformatf("resp_o[%0d].addr_ok", k), 128'(resp_o[k].addr_ok), 128'(ms.addrOk[k]));
          checkOutput($sformatf("resp_o[%0d].data_ok", k), 128'(resp_o[k].data_ok), 128'(ms.dataOk[k]));
          checkOutput($sformatf("resp_o[%0d].data", k), 128'(resp_o[k].data), 128'(ms.data[k]));
        end
      end
      if (dreq.valid && !prevValid) begin
        if (grantQ.size() == 0) begin
          noExpectation("grant");
        end else begin
          mg = grantQ.pop_front();
          checkOutput("grant_cycle", 128'(cycle), 128'(mg.cyc));
          checkOutput("grant_owner", 128'(grant_o), 128'(1) << mg.owner);
        end
      end
      prevValid = dreq.valid;
      for (int k = 0; k < N; k++) begin
        if (resp_o[k].data_ok) begin
          if (respQ.size() == 0) begin
            noExpectation($sformatf("resp_data_ok[%0d]", k));
          end else begin
            mr = respQ.pop_front();
            checkOutput("resp_owner", 128'(k), 128'(mr.owner));
            checkOutput("resp_cycle", 128'(cycle), 128'(mr.cyc));
            checkOutput("resp_data", 128'(resp_o[k].data), 128'(mr.data));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    resetModel();
    setKnobs(30, 3, 30, 20, 20);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_busy_o", 128'(busy_o), 128'(0));
    checkOutput("init_grant_o", 128'(grant_o), 128'(0));
    checkOutput("init_dreq", 128'(dreq), 128'(0));
    rst     = 1'b1;
    running = 1'b1;
    applyStimulus();

    setKnobs(30, 3, 30, 20, 20);
    repeat (600) stepCycle();
    setKnobs(100, 0, 40, 0, 10);
    repeat (400) stepCycle();
    setKnobs(60, 15, 25, 30, 20);
    repeat (600) stepCycle();
    setKnobs(50, 0, 10, 0, 0);
    resetMidBusy();
    repeat (5) stepCycle();
    setKnobs(30, 5, 30, 20, 20);
    repeat (300) stepCycle();
    setKnobs(0, 0, 50, 0, 0);
    repeat (60) stepCycle();

    @(negedge clk);
    #1;
    checkOutput("end_status_queue_empty", 128'(statusQ.size()), 128'(0));
    checkOutput("end_grant_queue_empty", 128'(grantQ.size()), 128'(0));
    checkOutput("end_resp_queue_empty", 128'(respQ.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
